// File: rtl/lvda_pio_pkg.sv
// Shared constants, types and helpers for the LVDA PIO discrete-output command path.
package lvda_pio_pkg;

  localparam int PIO_WORD_BITS = 26;

  localparam logic [8:0] PIO_ADDR_PCINF  = 9'h104;
  localparam logic [8:0] PIO_ADDR_INFO_A = 9'h105;
  localparam logic [8:0] PIO_ADDR_INFO_B = 9'h106;

  // Word layout, MSB-first serial order
  localparam int SR_SEL_BIT = 25;
  localparam int G_MSB      = 24;
  localparam int G_LSB      = 18;
  localparam int PAR_BIT    = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ARM   = 2'd2,
    ST_DRIVE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_PCINF  = 2'd1,
    CLS_INFO_A = 2'd2,
    CLS_INFO_B = 2'd3
  } addr_cls_e;

  typedef struct packed {
    logic       dos;
    logic       dor;
    logic [6:0] g_dv;
    logic [6:0] g_dvn;
    logic       pcinfv;
    logic       paav;
    logic       pabg1v;
    logic       infov;
  } dec_out_t;

  localparam dec_out_t DEC_NONE = '0;

  // fld holds word[SR_SEL_BIT:G_LSB]; fld[7] is the set/reset select
  function automatic dec_out_t decode_word(input addr_cls_e cls, input logic [7:0] fld);
    dec_out_t d;
    d       = DEC_NONE;
    d.dos   = fld[7];
    d.dor   = ~fld[7];
    for (int k = 0; k < 7; k++) begin
      d.g_dv[k] = fld[6-k];
    end
    d.g_dvn = ~d.g_dv;
    case (cls)
      CLS_PCINF:  d.pcinfv = 1'b1;
      CLS_INFO_A: begin d.infov = 1'b1; d.paav   = 1'b1; end
      CLS_INFO_B: begin d.infov = 1'b1; d.pabg1v = 1'b1; end
      default:    d = DEC_NONE;
    endcase
    return d;
  endfunction

  function automatic logic odd_parity_ok(input logic [PIO_WORD_BITS-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/disc_out_cmd_decoder_shifter.sv
// Serial-in word shift register with bit counter; done once WORD_BITS bits are in.
module pio_serial_shifter #(
  parameter int WORD_BITS = 26
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 bit_en_i,
  input  logic                 ser_i,
  output logic [WORD_BITS-1:0] word_o,
  output logic                 done_o
);

  localparam int CW = $clog2(WORD_BITS + 1);
  localparam logic [CW-1:0] FULL = CW'(WORD_BITS);

  logic [WORD_BITS-1:0] sr_q, sr_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  // Extra bits after a full word are dropped so the captured word stays intact.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (bit_en_i && (cnt_q != FULL)) begin
      sr_d  = {sr_q[WORD_BITS-2:0], ser_i};
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign word_o = sr_q;
  assign done_o = (cnt_q == FULL);

endmodule

// File: rtl/disc_out_cmd_decoder.sv
// LVDC PIO command decoder feeding the LVDA discrete-output registers.
// Build option DISC_OUT_PARITY_EN adds odd-parity checking and the sticky PERR output.
module disc_out_cmd_decoder
  import lvda_pio_pkg::*;
#(
  parameter int         WORD_BITS   = PIO_WORD_BITS,
  parameter logic [8:0] ADDR_PCINF  = PIO_ADDR_PCINF,
  parameter logic [8:0] ADDR_INFO_A = PIO_ADDR_INFO_A,
  parameter logic [8:0] ADDR_INFO_B = PIO_ADDR_INFO_B
) (
  input  logic       SIM_CLK,
  input  logic       SIM_RST,
  input  logic       PIO_STROBE,
  input  logic [8:0] PIO_ADDR,
  input  logic       BIT_EN,
  input  logic       DATA_SER,
  input  logic       Y1,
  output logic       DOS,
  output logic       DOR,
  output logic [6:0] G_DV,
  output logic [6:0] G_DVN,
  output logic       PCINFV,
  output logic       PAAV,
  output logic       PABG1V,
  output logic       INFOV,
  output logic       BUSY,
  output logic       OVERRUN
`ifdef DISC_OUT_PARITY_EN
  ,
  output logic       PERR
`endif
);

  state_e    state_q, state_d;
  addr_cls_e cls_q, cls_d, strobe_cls_s;
  dec_out_t  dec_q, dec_d;
  logic      y1_q;
  logic      busy_q;
  logic      overrun_q, overrun_d;
  logic      clr_s, shift_en_s, shift_done_s, y1_rise_s, par_fail_s;
  logic [WORD_BITS-1:0] word_s;

  assign shift_en_s = BIT_EN & (state_q == ST_SHIFT);
  assign y1_rise_s  = Y1 & ~y1_q;

  pio_serial_shifter #(
    .WORD_BITS(WORD_BITS)
  ) u_shifter (
    .clk_i   (SIM_CLK),
    .rst_i   (SIM_RST),
    .clr_i   (clr_s),
    .bit_en_i(shift_en_s),
    .ser_i   (DATA_SER),
    .word_o  (word_s),
    .done_o  (shift_done_s)
  );

`ifdef DISC_OUT_PARITY_EN
  logic perr_q;
  assign par_fail_s = ~odd_parity_ok(word_s);
`else
  logic unused_word_bits_s;
  assign par_fail_s         = 1'b0;
  assign unused_word_bits_s = ^word_s[G_LSB-1:0];
`endif

  // Address match against the three command addresses.
  always_comb begin
    if (PIO_ADDR == ADDR_PCINF) begin
      strobe_cls_s = CLS_PCINF;
    end else if (PIO_ADDR == ADDR_INFO_A) begin
      strobe_cls_s = CLS_INFO_A;
    end else if (PIO_ADDR == ADDR_INFO_B) begin
      strobe_cls_s = CLS_INFO_B;
    end else begin
      strobe_cls_s = CLS_NONE;
    end
  end

  // Command FSM: decoded outputs are loaded on ARM entry and held until DRIVE ends.
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    dec_d     = dec_q;
    clr_s     = 1'b0;
    overrun_d = overrun_q | (PIO_STROBE & (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (PIO_STROBE && (strobe_cls_s != CLS_NONE)) begin
          cls_d   = strobe_cls_s;
          clr_s   = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (shift_done_s) begin
          state_d = ST_ARM;
          if (par_fail_s) begin
            dec_d = DEC_NONE;
          end else begin
            dec_d = decode_word(cls_q, word_s[SR_SEL_BIT:G_LSB]);
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_ARM: begin
        if (par_fail_s) begin
          state_d = ST_IDLE;
          dec_d   = DEC_NONE;
        end else if (y1_rise_s) begin
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_DRIVE: begin
        if (!Y1) begin
          state_d = ST_IDLE;
          dec_d   = DEC_NONE;
        end else begin
          state_d = ST_DRIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        dec_d   = DEC_NONE;
      end
    endcase
  end

  // y1_q resets high so a Y1 already high at reset release is not taken as a rising edge.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state_q   <= ST_IDLE;
      cls_q     <= CLS_NONE;
      dec_q     <= DEC_NONE;
      y1_q      <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      dec_q     <= dec_d;
      y1_q      <= Y1;
      busy_q    <= (state_d != ST_IDLE);
      overrun_q <= overrun_d;
    end
  end

`ifdef DISC_OUT_PARITY_EN
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_q | ((state_q == ST_SHIFT) & shift_done_s & par_fail_s);
    end
  end

  assign PERR = perr_q;
`endif

  assign DOS     = dec_q.dos;
  assign DOR     = dec_q.dor;
  assign G_DV    = dec_q.g_dv;
  assign G_DVN   = dec_q.g_dvn;
  assign PCINFV  = dec_q.pcinfv;
  assign PAAV    = dec_q.paav;
  assign PABG1V  = dec_q.pabg1v;
  assign INFOV   = dec_q.infov;
  assign BUSY    = busy_q;
  assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_disc_out_cmd_decoder.sv
// Self-checking bench for disc_out_cmd_decoder using a behavioural command model.
module tb_disc_out_cmd_decoder;

  logic       SIM_CLK = 1'b0;
  logic       SIM_RST = 1'b1;
  logic       PIO_STROBE = 1'b0;
  logic [8:0] PIO_ADDR = 9'h000;
  logic       BIT_EN = 1'b0;
  logic       DATA_SER = 1'b0;
  logic       Y1 = 1'b0;
  logic       DOS, DOR, PCINFV, PAAV, PABG1V, INFOV, BUSY, OVERRUN;
  logic [6:0] G_DV, G_DVN;
`ifdef DISC_OUT_PARITY_EN
  logic       PERR;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_ovr  = 1'b0;

  disc_out_cmd_decoder dut (
    .SIM_CLK   (SIM_CLK),
    .SIM_RST   (SIM_RST),
    .PIO_STROBE(PIO_STROBE),
    .PIO_ADDR  (PIO_ADDR),
    .BIT_EN    (BIT_EN),
    .DATA_SER  (DATA_SER),
    .Y1        (Y1),
    .DOS       (DOS),
    .DOR       (DOR),
    .G_DV      (G_DV),
    .G_DVN     (G_DVN),
    .PCINFV    (PCINFV),
    .PAAV      (PAAV),
    .PABG1V    (PABG1V),
    .INFOV     (INFOV),
    .BUSY      (BUSY),
    .OVERRUN   (OVERRUN)
`ifdef DISC_OUT_PARITY_EN
    ,
    .PERR      (PERR)
`endif
  );

  always #5 SIM_CLK = ~SIM_CLK;

  function automatic logic [21:0] observed();
    return {DOS, DOR, G_DV, G_DVN, PCINFV, PAAV, PABG1V, INFOV, BUSY, OVERRUN};
  endfunction

  // Expected output bundle: active means a decoded command is being presented.
  function automatic logic [21:0] model(input bit active, input bit busy, input bit ovr,
                                        input logic [8:0] a, input logic [25:0] w);
    logic       dos, dor, pc, paa, pab, info;
    logic [6:0] g, gn;
    dos = 1'b0; dor = 1'b0; pc = 1'b0; paa = 1'b0; pab = 1'b0; info = 1'b0;
    g = 7'd0; gn = 7'd0;
    if (active) begin
      dos = w[25];
      dor = !w[25];
      for (int k = 0; k < 7; k++) g[k] = w[24-k];
      gn = ~g;
      if (a == 9'h104) pc = 1'b1;
      if (a == 9'h105) begin info = 1'b1; paa = 1'b1; end
      if (a == 9'h106) begin info = 1'b1; pab = 1'b1; end
    end
    return {dos, dor, g, gn, pc, paa, pab, info, busy ? 1'b1 : 1'b0, ovr};
  endfunction

  function automatic logic [25:0] fix_par(input logic [25:0] w);
    logic [25:0] r;
    r = w;
`ifdef DISC_OUT_PARITY_EN
    if ((^r) == 1'b0) r[0] = ~r[0];
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge SIM_CLK);
    #1;
  endtask

  task automatic start_cmd(input logic [8:0] a);
    PIO_ADDR   = a;
    PIO_STROBE = 1'b1;
    tick();
    PIO_STROBE = 1'b0;
  endtask

  // Shift word bits hi..lo MSB first, optionally with idle BIT_EN gaps.
  task automatic shift_range(input logic [25:0] w, input int hi, input int lo, input bit gaps);
    for (int i = hi; i >= lo; i--) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        BIT_EN   = 1'b0;
        DATA_SER = 1'($urandom_range(0, 1));
        tick();
      end
      BIT_EN   = 1'b1;
      DATA_SER = w[i];
      tick();
    end
    BIT_EN = 1'b0;
  endtask

  task automatic run_cmd(input string nm, input logic [8:0] a, input logic [25:0] w,
                         input int hi_cycles, input bit gaps);
    logic [21:0] e;
    Y1 = 1'b0;
    start_cmd(a);
    shift_range(w, 25, 0, gaps);
    tick();
    e = model(1'b1, 1'b1, exp_ovr, a, w);
    n_checks++;
    if (observed() !== e) begin
      n_fail++;
      $display("FAIL %s_arm: got %h expected %h", nm, observed(), e);
    end
    Y1 = 1'b1;
    for (int c = 0; c < hi_cycles; c++) begin
      tick();
      n_checks++;
      if (observed() !== e) begin
        n_fail++;
        $display("FAIL %s_drive%0d: got %h expected %h", nm, c, observed(), e);
      end
    end
    Y1 = 1'b0;
    tick();
    e = model(1'b0, 1'b0, exp_ovr, a, w);
    n_checks++;
    if (observed() !== e) begin
      n_fail++;
      $display("FAIL %s_release: got %h expected %h", nm, observed(), e);
    end
  endtask

  task automatic test_reset();
    logic [21:0] e;
    SIM_RST = 1'b1;
    Y1      = 1'b1;
    tick();
    tick();
    SIM_RST = 1'b0;
    exp_ovr = 1'b0;
    e = model(1'b0, 1'b0, 1'b0, 9'h000, 26'd0);
    n_checks++;
    if (observed() !== e) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", observed(), e);
    end
`ifdef DISC_OUT_PARITY_EN
    n_checks++;
    if (PERR !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_perr: got %b expected 0", PERR);
    end
`endif
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (observed() !== e) begin
        n_fail++;
        $display("FAIL reset_y1_high%0d: got %h expected %h", c, observed(), e);
      end
    end
    Y1 = 1'b0;
    tick();
  endtask

  task automatic test_pcinf();
    logic [25:0] w;
    w = fix_par(26'h2C00000);
    run_cmd("pcinf", 9'h104, w, 3, 1'b0);
    Y1 = 1'b0;
    start_cmd(9'h104);
    shift_range(w, 25, 0, 1'b0);
    tick();
    n_checks++;
    if ({DOS, DOR, G_DV, G_DVN, PCINFV} !== {1'b1, 1'b0, 7'b0000110, 7'b1111001, 1'b1}) begin
      n_fail++;
      $display("FAIL pcinf_literal: got %b%b %b %b %b expected 10 0000110 1111001 1",
               DOS, DOR, G_DV, G_DVN, PCINFV);
    end
    Y1 = 1'b1;
    tick();
    Y1 = 1'b0;
    tick();
  endtask

  task automatic test_info_b();
    run_cmd("info_b", 9'h106, fix_par(26'h0000000), 2, 1'b0);
  endtask

  task automatic test_y1_phase();
    logic [25:0] w;
    logic [21:0] e;
    w = fix_par(26'h1540000);
    Y1 = 1'b0;
    start_cmd(9'h105);
    Y1 = 1'b1;
    shift_range(w, 25, 0, 1'b0);
    tick();
    e = model(1'b1, 1'b1, exp_ovr, 9'h105, w);
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (observed() !== e) begin
        n_fail++;
        $display("FAIL y1_phase_arm%0d: got %h expected %h", c, observed(), e);
      end
      tick();
    end
    Y1 = 1'b0;
    tick();
    n_checks++;
    if (observed() !== e) begin
      n_fail++;
      $display("FAIL y1_phase_stay_arm: got %h expected %h", observed(), e);
    end
    Y1 = 1'b1;
    tick();
    n_checks++;
    if (observed() !== e) begin
      n_fail++;
      $display("FAIL y1_phase_drive: got %h expected %h", observed(), e);
    end
    Y1 = 1'b0;
    tick();
    e = model(1'b0, 1'b0, exp_ovr, 9'h105, w);
    n_checks++;
    if (observed() !== e) begin
      n_fail++;
      $display("FAIL y1_phase_release: got %h expected %h", observed(), e);
    end
  endtask

  task automatic test_bad_addr();
    logic [21:0] e;
    logic [8:0]  bad[3];
    bad[0] = 9'h000; bad[1] = 9'h107; bad[2] = 9'h103;
    e = model(1'b0, 1'b0, exp_ovr, 9'h000, 26'd0);
    for (int i = 0; i < 3; i++) begin
      start_cmd(bad[i]);
      shift_range(26'h3FFFFFF, 25, 20, 1'b0);
      n_checks++;
      if (observed() !== e) begin
        n_fail++;
        $display("FAIL bad_addr_%h: got %h expected %h", bad[i], observed(), e);
      end
    end
  endtask

  task automatic test_overrun();
    logic [25:0] w;
    logic [21:0] e;
    w = fix_par(26'h27C0000);
    Y1 = 1'b0;
    start_cmd(9'h104);
    shift_range(w, 25, 21, 1'b0);
    start_cmd(9'h105);
    exp_ovr = 1'b1;
    n_checks++;
    if ((OVERRUN !== 1'b1) || (BUSY !== 1'b1)) begin
      n_fail++;
      $display("FAIL overrun_flag: got ovr=%b busy=%b expected ovr=1 busy=1", OVERRUN, BUSY);
    end
    shift_range(w, 20, 0, 1'b0);
    tick();
    e = model(1'b1, 1'b1, 1'b1, 9'h104, w);
    n_checks++;
    if (observed() !== e) begin
      n_fail++;
      $display("FAIL overrun_cmd_arm: got %h expected %h", observed(), e);
    end
    Y1 = 1'b1;
    tick();
    Y1 = 1'b0;
    tick();
    e = model(1'b0, 1'b0, 1'b1, 9'h104, w);
    n_checks++;
    if (observed() !== e) begin
      n_fail++;
      $display("FAIL overrun_sticky: got %h expected %h", observed(), e);
    end
  endtask

  task automatic test_reset_mid();
    logic [21:0] e;
    start_cmd(9'h106);
    shift_range(26'h3FFFFFF, 25, 16, 1'b0);
    SIM_RST = 1'b1;
    tick();
    SIM_RST = 1'b0;
    exp_ovr = 1'b0;
    e = model(1'b0, 1'b0, 1'b0, 9'h000, 26'd0);
    n_checks++;
    if (observed() !== e) begin
      n_fail++;
      $display("FAIL reset_mid: got %h expected %h", observed(), e);
    end
    run_cmd("after_reset", 9'h104, fix_par(26'h3A40000), 1, 1'b0);
  endtask

  task automatic test_random();
    logic [8:0] addrs[3];
    addrs[0] = 9'h104; addrs[1] = 9'h105; addrs[2] = 9'h106;
    for (int n = 0; n < 24; n++) begin
      run_cmd("random", addrs[$urandom_range(0, 2)], fix_par(26'($urandom)),
              int'($urandom_range(1, 4)), 1'b1);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end
  endtask

`ifdef DISC_OUT_PARITY_EN
  task automatic test_parity();
    logic [21:0] e;
    Y1 = 1'b0;
    start_cmd(9'h104);
    shift_range(26'h2C00001, 25, 0, 1'b0);
    tick();
    e = model(1'b0, 1'b1, exp_ovr, 9'h104, 26'd0);
    n_checks++;
    if ((observed() !== e) || (PERR !== 1'b1)) begin
      n_fail++;
      $display("FAIL parity_arm: got %h perr=%b expected %h perr=1", observed(), PERR, e);
    end
    tick();
    e = model(1'b0, 1'b0, exp_ovr, 9'h104, 26'd0);
    n_checks++;
    if ((observed() !== e) || (PERR !== 1'b1)) begin
      n_fail++;
      $display("FAIL parity_idle: got %h perr=%b expected %h perr=1", observed(), PERR, e);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pcinf();
    test_info_b();
    test_y1_phase();
    test_bad_addr();
    test_overrun();
    test_reset_mid();
    test_random();
`ifdef DISC_OUT_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
